// File: rtl/axi_pkg.sv
// Shared constants, FSM state type and write-strobe helper for the
// N-port SRAM-like to AXI3 master.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;

    localparam int ID_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B
    } state_t;

    // Byte lanes touched by a single-beat write; anything wider than a
    // half-word (including the reserved size 3) is a full word.
    function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: strb_of = 4'b0001 << addr_lo;
            SIZE_HALF: strb_of = 4'b0011 << addr_lo;
            default:   strb_of = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/axi_nport_master_if.sv
// AXI3 master-side channel bundle (read address/data, write
// address/data/response) with master and slave views.
interface axi_nport_master_if #(
    parameter int LEN_W = 8
);
    import axi_pkg::*;

    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic [1:0]       arlock;
    logic [3:0]       arcache;
    logic [2:0]       arprot;
    logic             arvalid;
    logic             arready;

    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    logic [ID_W-1:0]  awid;
    logic [31:0]      awaddr;
    logic [LEN_W-1:0] awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic [1:0]       awlock;
    logic [3:0]       awcache;
    logic [2:0]       awprot;
    logic             awvalid;
    logic             awready;

    logic [ID_W-1:0]  wid;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;

    logic [ID_W-1:0]  bid;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the port after the last one
// that was granted; the pointer only moves when the grant is consumed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] grant_idx;
    logic          found;

    // Scan requests starting at the priority pointer and take the first one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Move the priority pointer past the port that was just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axi_nport_master.sv
// Arbitrates NPORT SRAM-like request ports onto a single AXI3 master with
// one transaction in flight: reads are one INCR burst, writes one beat.
module axi_nport_master
    import axi_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int LEN_W = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT-1:0]       wr,
    input  logic [2*NPORT-1:0]     size,
    input  logic [32*NPORT-1:0]    addr,
    input  logic [32*NPORT-1:0]    wdata,
    input  logic [LEN_W*NPORT-1:0] len,
    output logic [NPORT-1:0]       addr_ok,
    output logic [NPORT-1:0]       data_ok,
    output logic [31:0]            rdata,
    output logic                   rlast_o,
    output logic                   resp_err,
    axi_nport_master_if.master     axi
);
    localparam int PW = $clog2(NPORT);

    state_t           state;
    state_t           state_next;
    logic [NPORT-1:0] grant;
    logic             grant_any;
    logic             start;
    logic [PW-1:0]    g_idx;
    logic [1:0]       g_size;

    logic [1:0]       size_a  [NPORT];
    logic [31:0]      addr_a  [NPORT];
    logic [31:0]      wdata_a [NPORT];
    logic [LEN_W-1:0] len_a   [NPORT];

    logic [PW-1:0]    cur_port;
    logic [31:0]      l_addr;
    logic [31:0]      l_wdata;
    logic [LEN_W-1:0] l_len;
    logic [1:0]       l_size;
    logic [3:0]       l_strb;
    logic             ar_valid;
    logic             aw_valid;
    logic             w_valid;
    logic             aw_done;
    logic             w_done;
    logic             unused_ok;

    for (genvar p = 0; p < NPORT; p++) begin : g_unpack
        assign size_a[p]  = size[2*p +: 2];
        assign addr_a[p]  = addr[32*p +: 32];
        assign wdata_a[p] = wdata[32*p +: 32];
        assign len_a[p]   = len[LEN_W*p +: LEN_W];
    end

    rr_arbiter #(.N(NPORT)) u_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (req),
        .advance (start),
        .grant   (grant)
    );

    assign grant_any = |grant;
    assign start     = (state == IDLE) && grant_any;
    assign g_size    = (size_a[g_idx] == 2'd3) ? SIZE_WORD : size_a[g_idx];
    assign aw_done   = !aw_valid || axi.awready;
    assign w_done    = !w_valid || axi.wready;

    // Convert the one-hot grant into a port index.
    always_comb begin
        g_idx = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
                g_idx = PW'(p);
            end
        end
    end

    // State register; a reset mid-burst drops the transaction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the per-port handshakes, which only ever go to the owner.
    always_comb begin
        state_next = state;
        addr_ok    = '0;
        data_ok    = '0;
        rlast_o    = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                addr_ok = grant;
                if (grant_any) begin
                    state_next = wr[g_idx] ? AW_W : AR;
                end
            end
            AR: begin
                if (axi.arready) begin
                    state_next = R;
                end
            end
            R: begin
                if (axi.rvalid) begin
                    data_ok[cur_port] = 1'b1;
                    rlast_o           = axi.rlast;
                    resp_err          = (axi.rresp != RESP_OKAY);
                    if (axi.rlast) begin
                        state_next = IDLE;
                    end
                end
            end
            AW_W: begin
                if (aw_done && w_done) begin
                    state_next = B;
                end
            end
            B: begin
                if (axi.bvalid) begin
                    data_ok[cur_port] = 1'b1;
                    resp_err          = (axi.bresp != RESP_OKAY);
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request and run the registered AXI valids.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_port <= '0;
            l_addr   <= '0;
            l_wdata  <= '0;
            l_len    <= '0;
            l_size   <= '0;
            l_strb   <= '0;
            ar_valid <= 1'b0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_port <= g_idx;
                        l_addr   <= addr_a[g_idx];
                        l_wdata  <= wdata_a[g_idx];
                        l_len    <= len_a[g_idx];
                        l_size   <= g_size;
                        l_strb   <= strb_of(g_size, addr_a[g_idx][1:0]);
                        ar_valid <= !wr[g_idx];
                        aw_valid <= wr[g_idx];
                        w_valid  <= wr[g_idx];
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        ar_valid <= 1'b0;
                    end
                end
                AW_W: begin
                    if (axi.awready) begin
                        aw_valid <= 1'b0;
                    end
                    if (axi.wready) begin
                        w_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi.arid    = ID_W'(cur_port);
    assign axi.araddr  = l_addr;
    assign axi.arlen   = l_len;
    assign axi.arsize  = {1'b0, l_size};
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = ar_valid;
    assign axi.rready  = (state == R);

    assign axi.awid    = ID_W'(cur_port);
    assign axi.awaddr  = l_addr;
    assign axi.awlen   = '0;
    assign axi.awsize  = {1'b0, l_size};
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.awvalid = aw_valid;
    assign axi.wid     = ID_W'(cur_port);
    assign axi.wdata   = l_wdata;
    assign axi.wstrb   = l_strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_valid;
    assign axi.bready  = (state == B);

    assign rdata = axi.rdata;

    // Response IDs are redundant with a single transaction outstanding.
    assign unused_ok = ^{axi.rid, axi.bid};

endmodule

// File: tb/tb_axi_nport_master.sv
// Randomized bench for axi_nport_master: a behavioural AXI slave plus a
// round-robin / strobe reference model, with directed corner cases first.
module tb_axi_nport_master;

    localparam int NPORT = 3;
    localparam int LEN_W = 8;

    logic                   aclk;
    logic                   aresetn;
    logic [NPORT-1:0]       req;
    logic [NPORT-1:0]       wr;
    logic [2*NPORT-1:0]     size;
    logic [32*NPORT-1:0]    addr;
    logic [32*NPORT-1:0]    wdata;
    logic [LEN_W*NPORT-1:0] len;
    logic [NPORT-1:0]       addr_ok;
    logic [NPORT-1:0]       data_ok;
    logic [31:0]            rdata;
    logic                   rlast_o;
    logic                   resp_err;

    axi_nport_master_if #(.LEN_W(LEN_W)) axi ();

    axi_nport_master #(.NPORT(NPORT), .LEN_W(LEN_W)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .len      (len),
        .addr_ok  (addr_ok),
        .data_ok  (data_ok),
        .rdata    (rdata),
        .rlast_o  (rlast_o),
        .resp_err (resp_err),
        .axi      (axi)
    );

    // Free-running 100 MHz clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int tests_run;
    int tests_failed;
    int rr_last;

    logic             p_wr    [NPORT];
    logic [1:0]       p_size  [NPORT];
    logic [31:0]      p_addr  [NPORT];
    logic [31:0]      p_wdata [NPORT];
    logic [LEN_W-1:0] p_len   [NPORT];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        int         nbytes;
        logic [7:0] m;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (nbytes == 4) return 4'hF;
        m = 8'((1 << nbytes) - 1) << a[1:0];
        return m[3:0];
    endfunction

    task automatic drive_inputs();
        for (int p = 0; p < NPORT; p++) begin
            wr[p]                  = p_wr[p];
            size[2*p +: 2]         = p_size[p];
            addr[32*p +: 32]       = p_addr[p];
            wdata[32*p +: 32]      = p_wdata[p];
            len[LEN_W*p +: LEN_W]  = p_len[p];
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d, input int ln);
        p_wr[p]    = w;
        p_size[p]  = sz;
        p_addr[p]  = a;
        p_wdata[p] = d;
        p_len[p]   = LEN_W'(ln);
        req[p]     = 1'b1;
    endtask

    task automatic serve_read(input int g, input int err_beat, input int abort_beat,
                              input logic [31:0] fixed_d);
        logic [1:0]  esz;
        logic [31:0] d;
        int          ln;
        int          gap;
        esz = (p_size[g] == 2'd3) ? 2'd2 : p_size[g];
        ln  = int'(p_len[g]);
        #1;
        checkOutput("busy_addr_ok", 64'(addr_ok), 64'd0);
        checkOutput("arvalid", 64'(axi.arvalid), 64'd1);
        checkOutput("arid", 64'(axi.arid), 64'(g));
        checkOutput("araddr", 64'(axi.araddr), 64'(p_addr[g]));
        checkOutput("arlen", 64'(axi.arlen), 64'(ln));
        checkOutput("arsize", 64'(axi.arsize), 64'({1'b0, esz}));
        checkOutput("arburst", 64'(axi.arburst), 64'd1);
        gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
            @(posedge aclk);
            @(negedge aclk);
        end
        axi.arready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        axi.arready = 1'b0;
        for (int b = 0; b <= ln; b++) begin
            if (b == abort_beat) begin
                aresetn = 1'b0;
                #1;
                checkOutput("rst_arvalid", 64'(axi.arvalid), 64'd0);
                checkOutput("rst_awvalid", 64'(axi.awvalid), 64'd0);
                checkOutput("rst_wvalid", 64'(axi.wvalid), 64'd0);
                checkOutput("rst_rready", 64'(axi.rready), 64'd0);
                checkOutput("rst_data_ok", 64'(data_ok), 64'd0);
                return;
            end
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                #1;
                checkOutput("gap_data_ok", 64'(data_ok), 64'd0);
                @(posedge aclk);
                @(negedge aclk);
            end
            d = (b == 0 && fixed_d != 32'd0) ? fixed_d : $urandom;
            axi.rdata  = d;
            axi.rlast  = (b == ln);
            axi.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            axi.rvalid = 1'b1;
            #1;
            checkOutput("r_data_ok", 64'(data_ok), 64'd1 << g);
            checkOutput("r_rdata", 64'(rdata), 64'(d));
            checkOutput("r_rlast_o", 64'(rlast_o), 64'(b == ln));
            checkOutput("r_resp_err", 64'(resp_err), 64'(b == err_beat));
            checkOutput("r_rready", 64'(axi.rready), 64'd1);
            @(posedge aclk);
            @(negedge aclk);
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            axi.rresp  = 2'b00;
        end
        #1;
        checkOutput("r_end_rready", 64'(axi.rready), 64'd0);
    endtask

    task automatic serve_write(input int g, input int order, input logic [1:0] bresp_v);
        logic [1:0] esz;
        int         gap;
        esz = (p_size[g] == 2'd3) ? 2'd2 : p_size[g];
        #1;
        checkOutput("busy_addr_ok", 64'(addr_ok), 64'd0);
        checkOutput("awvalid", 64'(axi.awvalid), 64'd1);
        checkOutput("wvalid", 64'(axi.wvalid), 64'd1);
        checkOutput("awaddr", 64'(axi.awaddr), 64'(p_addr[g]));
        checkOutput("awlen", 64'(axi.awlen), 64'd0);
        checkOutput("awsize", 64'(axi.awsize), 64'({1'b0, esz}));
        checkOutput("awburst", 64'(axi.awburst), 64'd1);
        checkOutput("awid", 64'(axi.awid), 64'(g));
        checkOutput("wid", 64'(axi.wid), 64'(g));
        checkOutput("wlast", 64'(axi.wlast), 64'd1);
        checkOutput("wstrb", 64'(axi.wstrb), 64'(exp_strb(p_size[g], p_addr[g])));
        checkOutput("wdata", 64'(axi.wdata), 64'(p_wdata[g]));
        if (order == 2) begin
            axi.awready = 1'b1;
            axi.wready  = 1'b1;
        end else if (order == 0) begin
            axi.awready = 1'b1;
        end else begin
            axi.wready = 1'b1;
        end
        @(posedge aclk);
        @(negedge aclk);
        if (order != 2) begin
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            #1;
            checkOutput("half_awvalid", 64'(axi.awvalid), 64'(order == 1));
            checkOutput("half_wvalid", 64'(axi.wvalid), 64'(order == 0));
            checkOutput("half_data_ok", 64'(data_ok), 64'd0);
            if (order == 0) axi.wready = 1'b1;
            else            axi.awready = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        #1;
        checkOutput("b_awvalid", 64'(axi.awvalid), 64'd0);
        checkOutput("b_wvalid", 64'(axi.wvalid), 64'd0);
        checkOutput("b_bready", 64'(axi.bready), 64'd1);
        gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
            checkOutput("b_wait_data_ok", 64'(data_ok), 64'd0);
            @(posedge aclk);
            @(negedge aclk);
            #1;
        end
        axi.bresp  = bresp_v;
        axi.bvalid = 1'b1;
        #1;
        checkOutput("b_data_ok", 64'(data_ok), 64'd1 << g);
        checkOutput("b_resp_err", 64'(resp_err), 64'(bresp_v != 2'b00));
        @(posedge aclk);
        @(negedge aclk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        #1;
        checkOutput("b_end_bready", 64'(axi.bready), 64'd0);
    endtask

    // Must be entered in the low clock phase; predicts the round-robin
    // winner among the raised requests and then plays the AXI slave.
    task automatic applyStimulus(input int err_beat, input int order, input logic [1:0] bresp_v,
                                 input int abort_beat, input logic [31:0] fixed_d);
        int g;
        drive_inputs();
        #1;
        g = -1;
        for (int i = 1; i <= NPORT; i++) begin
            if (g < 0 && req[(rr_last + i) % NPORT]) g = (rr_last + i) % NPORT;
        end
        if (g < 0) return;
        checkOutput("grant_addr_ok", 64'(addr_ok), 64'd1 << g);
        checkOutput("grant_arvalid", 64'(axi.arvalid), 64'd0);
        checkOutput("grant_awvalid", 64'(axi.awvalid), 64'd0);
        @(posedge aclk);
        rr_last = g;
        @(negedge aclk);
        req[g] = 1'b0;
        if (p_wr[g]) serve_write(g, order, bresp_v);
        else         serve_read(g, err_beat, abort_beat, fixed_d);
    endtask

    // Directed corner cases, then a randomized mix of ports and directions.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rr_last      = NPORT - 1;
        req          = '0;
        for (int p = 0; p < NPORT; p++) begin
            p_wr[p] = 1'b0; p_size[p] = '0; p_addr[p] = '0; p_wdata[p] = '0; p_len[p] = '0;
        end
        drive_inputs();
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        axi.rid = '0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        axi.bid = '0;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        checkOutput("reset_addr_ok", 64'(addr_ok), 64'd0);
        checkOutput("reset_data_ok", 64'(data_ok), 64'd0);
        checkOutput("reset_arvalid", 64'(axi.arvalid), 64'd0);
        checkOutput("reset_awvalid", 64'(axi.awvalid), 64'd0);
        checkOutput("reset_wvalid", 64'(axi.wvalid), 64'd0);
        checkOutput("reset_rready", 64'(axi.rready), 64'd0);
        checkOutput("reset_bready", 64'(axi.bready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        set_port(0, 1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 0);
        applyStimulus(-1, 0, 2'b00, -1, 32'hDEAD_BEEF);
        set_port(1, 1'b0, 2'd2, 32'h0000_1000, 32'd0, 7);
        applyStimulus(-1, 0, 2'b00, -1, 32'd0);
        for (int o = 0; o < 3; o++) begin
            set_port(1, 1'b1, 2'd0, 32'h8000_0003, 32'h1122_3344, 0);
            applyStimulus(-1, o, 2'b00, -1, 32'd0);
        end
        set_port(0, 1'b1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D, 0);
        applyStimulus(-1, 2, 2'b10, -1, 32'd0);
        set_port(2, 1'b0, 2'd1, 32'h0000_0200, 32'd0, 3);
        applyStimulus(2, 0, 2'b00, -1, 32'd0);

        set_port(0, 1'b0, 2'd2, 32'h0000_3000, 32'd0, 7);
        applyStimulus(-1, 0, 2'b00, 3, 32'd0);
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        @(negedge aclk);
        aresetn = 1'b1;
        rr_last = NPORT - 1;
        @(negedge aclk);

        set_port(0, 1'b0, 2'd2, 32'h0000_4000, 32'd0, 0);
        set_port(1, 1'b0, 2'd2, 32'h0000_5000, 32'd0, 0);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(-1, 0, 2'b00, -1, 32'd0);
            req[0] = 1'b1;
            req[1] = 1'b1;
        end
        req = '0;

        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!req[p] && $urandom_range(0, 1) == 1) begin
                    set_port(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             $urandom, $urandom, $urandom_range(0, 7));
                end
            end
            if (req == '0) begin
                set_port($urandom_range(0, NPORT - 1), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 7));
            end
            applyStimulus($urandom_range(0, 8), $urandom_range(0, 2), 2'($urandom_range(0, 3)),
                          -1, 32'd0);
        end
        req = '0;
        repeat (2) @(negedge aclk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
